// File: rtl/plic_gateway.sv
// -----------------------------------------------------------------------------
// plic_gateway
//
// Per-source interrupt gateway placed in front of the PLIC core. Every raw
// source line is synchronized into the PCLK domain, then converted into a
// single-cycle pending-set request. Once a request is forwarded, the source is
// blocked until the core reports completion for it. Sources configured for
// rising-edge mode queue the edges that arrive while blocked in a saturating
// counter, and replay them one at a time after each completion.
//
// Ports:
//   PCLK       in   1        clock for all logic
//   PRESETn    in   1        asynchronous active-low reset
//   src        in   SRC_NUM  raw interrupt lines, asynchronous to PCLK
//   edge_mode  in   SRC_NUM  1 = rising-edge source, 0 = level-high source
//   complete   in   SRC_NUM  one-cycle pulse: handler for source i is done
//   ovf_clr    in   SRC_NUM  one-cycle pulse clearing edge_ovf[i]
//   ip_set     out  SRC_NUM  registered one-cycle pulse setting core pending i
//   busy       out  SRC_NUM  source i forwarded and awaiting complete
//   edge_ovf   out  SRC_NUM  sticky: an edge was dropped on a full counter
// -----------------------------------------------------------------------------
module plic_gateway #(
  parameter int SRC_NUM     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [SRC_NUM-1:0] src,
  input  logic [SRC_NUM-1:0] edge_mode,
  input  logic [SRC_NUM-1:0] complete,
  input  logic [SRC_NUM-1:0] ovf_clr,
  output logic [SRC_NUM-1:0] ip_set,
  output logic [SRC_NUM-1:0] busy,
  output logic [SRC_NUM-1:0] edge_ovf
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_WAIT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Sources never interact, so each one gets a fully private slice of logic.
  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   src_s;
    logic                   src_q;
    logic                   rise;

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ip_set_q, ip_set_d;
    logic                   ovf_q, ovf_d;
    logic                   ovf_hit;

    // Synchronizer chain plus one extra flop for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        sync_q <= '0;
        src_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], src[i]};
        src_q  <= src_s;
      end
    end

    assign src_s = sync_q[SYNC_STAGES-1];
    assign rise  = src_s & ~src_q;

    always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      ip_set_d = 1'b0;
      ovf_hit  = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (edge_mode[i]) begin
            if ((cnt_q != '0) || rise) begin
              ip_set_d = 1'b1;
              state_d  = ST_WAIT;
              // cnt + rise - 1: a fresh edge is forwarded directly, otherwise
              // one queued edge is consumed.
              if (!rise) begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end
          end else if (src_s) begin
            ip_set_d = 1'b1;
            state_d  = ST_WAIT;
          end
        end

        default: begin  // ST_WAIT
          // Completion returns to IDLE; any new request is only evaluated
          // from IDLE in the next cycle, so two pulses are never adjacent.
          if (complete[i]) begin
            state_d = ST_IDLE;
          end
          if (edge_mode[i] && rise) begin
            if (cnt_q == CNT_MAX) begin
              ovf_hit = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
      endcase

      // Level sources never queue anything.
      if (!edge_mode[i]) begin
        cnt_d = '0;
      end

      // A new overflow outranks a clear arriving in the same cycle.
      ovf_d = ovf_hit | (ovf_q & ~ovf_clr[i]);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        ip_set_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        ip_set_q <= ip_set_d;
        ovf_q    <= ovf_d;
      end
    end

    assign ip_set[i]   = ip_set_q;
    assign busy[i]     = (state_q == ST_WAIT);
    assign edge_ovf[i] = ovf_q;
  end

endmodule
